// File: rtl/vx_socket_mem_arb_pkg.sv
// Shared constants and width helpers for the socket memory arbiter.
package vx_socket_mem_arb_pkg;

  localparam int unsigned SOCKET_ARB_NUM_INPUTS = 4;

  function automatic int unsigned socket_arb_sel_bits(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  localparam int unsigned SOCKET_ARB_SEL_BITS = socket_arb_sel_bits(SOCKET_ARB_NUM_INPUTS);

  // Output tag carries the input index in its LSBs.
  function automatic int unsigned socket_arb_out_tag_width(input int unsigned tag_w,
                                                           input int unsigned n);
    return tag_w + socket_arb_sel_bits(n);
  endfunction

endpackage

// File: rtl/vx_socket_mem_arb_if.sv
// Bundle of per-core request/response ports plus the merged port toward the shared cache.
interface vx_socket_mem_arb_if #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_SIZE  = 4,
  parameter int unsigned TAG_WIDTH  = 8
);
  import vx_socket_mem_arb_pkg::*;

  localparam int unsigned DATA_WIDTH    = 8 * DATA_SIZE;
  localparam int unsigned OUT_TAG_WIDTH = socket_arb_out_tag_width(TAG_WIDTH, NUM_INPUTS);

  logic [NUM_INPUTS-1:0]                 req_in_valid;
  logic [NUM_INPUTS-1:0]                 req_in_rw;
  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0] req_in_addr;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] req_in_data;
  logic [NUM_INPUTS-1:0][DATA_SIZE-1:0]  req_in_byteen;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]  req_in_tag;
  logic [NUM_INPUTS-1:0]                 req_in_ready;

  logic [NUM_INPUTS-1:0]                 rsp_in_valid;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] rsp_in_data;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]  rsp_in_tag;
  logic [NUM_INPUTS-1:0]                 rsp_in_ready;

  logic                     req_out_valid;
  logic                     req_out_rw;
  logic [ADDR_WIDTH-1:0]    req_out_addr;
  logic [DATA_WIDTH-1:0]    req_out_data;
  logic [DATA_SIZE-1:0]     req_out_byteen;
  logic [OUT_TAG_WIDTH-1:0] req_out_tag;
  logic                     req_out_ready;

  logic                     rsp_out_valid;
  logic [DATA_WIDTH-1:0]    rsp_out_data;
  logic [OUT_TAG_WIDTH-1:0] rsp_out_tag;
  logic                     rsp_out_ready;

  // Environment side: cores plus the downstream cache.
  modport master (
    output req_in_valid, req_in_rw, req_in_addr, req_in_data, req_in_byteen, req_in_tag,
    input  req_in_ready,
    input  rsp_in_valid, rsp_in_data, rsp_in_tag,
    output rsp_in_ready,
    input  req_out_valid, req_out_rw, req_out_addr, req_out_data, req_out_byteen, req_out_tag,
    output req_out_ready,
    output rsp_out_valid, rsp_out_data, rsp_out_tag,
    input  rsp_out_ready
  );

  // Arbiter side.
  modport slave (
    input  req_in_valid, req_in_rw, req_in_addr, req_in_data, req_in_byteen, req_in_tag,
    output req_in_ready,
    output rsp_in_valid, rsp_in_data, rsp_in_tag,
    input  rsp_in_ready,
    output req_out_valid, req_out_rw, req_out_addr, req_out_data, req_out_byteen, req_out_tag,
    input  req_out_ready,
    input  rsp_out_valid, rsp_out_data, rsp_out_tag,
    output rsp_out_ready
  );

endinterface

// File: rtl/vx_socket_mem_arb_rr_grant.sv
// Round-robin priority encoder: first valid input at or after ptr, wrapping modulo NUM_INPUTS.
module vx_rr_grant #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_BITS   = 2
) (
  input  logic [NUM_INPUTS-1:0] valid_i,
  input  logic [SEL_BITS-1:0]   ptr_i,
  output logic [NUM_INPUTS-1:0] grant_c_o,
  output logic [SEL_BITS-1:0]   idx_c_o,
  output logic                  found_c_o
);

  logic [SEL_BITS:0]   pos_c;
  logic [SEL_BITS-1:0] cand_c;

  always_comb begin
    grant_c_o = '0;
    idx_c_o   = '0;
    found_c_o = 1'b0;
    pos_c     = '0;
    cand_c    = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      pos_c = {1'b0, ptr_i} + (SEL_BITS+1)'(k);
      if (pos_c >= (SEL_BITS+1)'(NUM_INPUTS)) pos_c = pos_c - (SEL_BITS+1)'(NUM_INPUTS);
      cand_c = SEL_BITS'(pos_c);
      if (!found_c_o && valid_i[cand_c]) begin
        found_c_o         = 1'b1;
        grant_c_o[cand_c] = 1'b1;
        idx_c_o           = cand_c;
      end
    end
  end

endmodule

// File: rtl/vx_socket_mem_arb.sv
// Merges per-core cache request ports into one port with round-robin arbitration,
// tagging each request with its source index and routing responses back by that index.
module vx_socket_mem_arb
  import vx_socket_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_SIZE  = 4,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned OUT_REG    = 1
) (
  input  logic               clk,
  input  logic               reset,
  vx_socket_mem_arb_if.slave bus_io
);

  localparam int unsigned SEL_BITS      = socket_arb_sel_bits(NUM_INPUTS);
  localparam int unsigned DATA_WIDTH    = 8 * DATA_SIZE;
  localparam int unsigned OUT_TAG_WIDTH = socket_arb_out_tag_width(TAG_WIDTH, NUM_INPUTS);
  localparam int unsigned REQ_WIDTH     = 1 + ADDR_WIDTH + DATA_WIDTH + DATA_SIZE + OUT_TAG_WIDTH;

  logic [SEL_BITS-1:0]   ptr_q, ptr_d;
  logic [NUM_INPUTS-1:0] grant_c;
  logic [SEL_BITS-1:0]   grant_idx_c;
  logic                  grant_vld_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  out_valid_c;
  logic [REQ_WIDTH-1:0]  req_mux_c;
  logic [REQ_WIDTH-1:0]  req_head_c;
  logic [SEL_BITS-1:0]   rsp_sel_c;

  vx_rr_grant #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_BITS   (SEL_BITS)
  ) u_rr_grant (
    .valid_i   (bus_io.req_in_valid),
    .ptr_i     (ptr_q),
    .grant_c_o (grant_c),
    .idx_c_o   (grant_idx_c),
    .found_c_o (grant_vld_c)
  );

  assign req_mux_c = {bus_io.req_in_rw[grant_idx_c],
                      bus_io.req_in_addr[grant_idx_c],
                      bus_io.req_in_data[grant_idx_c],
                      bus_io.req_in_byteen[grant_idx_c],
                      bus_io.req_in_tag[grant_idx_c],
                      grant_idx_c};

  assign push_c              = grant_vld_c & accept_c;
  assign bus_io.req_in_ready = grant_c & {NUM_INPUTS{accept_c}};

  // Priority moves just past the winner only when it actually hands off.
  always_comb begin
    ptr_d = ptr_q;
    if (push_c) begin
      ptr_d = (32'(grant_idx_c) == NUM_INPUTS - 1) ? '0 : grant_idx_c + SEL_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  if (OUT_REG != 0) begin : g_skid
    logic [1:0][REQ_WIDTH-1:0] mem_q, mem_d;
    logic [1:0]                count_q, count_d;
    logic                      wr_q, wr_d, rd_q, rd_d;
    logic                      pop_c;

    assign accept_c    = reset & (count_q != 2'd2);
    assign out_valid_c = reset & (count_q != 2'd0);
    assign pop_c       = out_valid_c & bus_io.req_out_ready;
    assign req_head_c  = mem_q[rd_q];

    always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_c) begin
        mem_d[wr_q] = req_mux_c;
        wr_d        = ~wr_q;
      end
      if (pop_c) rd_d = ~rd_q;
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        count_q <= '0;
        wr_q    <= 1'b0;
        rd_q    <= 1'b0;
      end else begin
        count_q <= count_d;
        wr_q    <= wr_d;
        rd_q    <= rd_d;
      end
    end

    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end
  end else begin : g_comb
    assign accept_c    = reset & bus_io.req_out_ready;
    assign out_valid_c = reset & grant_vld_c;
    assign req_head_c  = req_mux_c;
  end

  assign bus_io.req_out_valid = out_valid_c;
  assign {bus_io.req_out_rw, bus_io.req_out_addr, bus_io.req_out_data,
          bus_io.req_out_byteen, bus_io.req_out_tag} = req_head_c;

  // Responses steer by index; an index beyond NUM_INPUTS is swallowed with ready held high.
  assign rsp_sel_c = bus_io.rsp_out_tag[SEL_BITS-1:0];

  always_comb begin
    bus_io.rsp_in_valid  = '0;
    bus_io.rsp_out_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (rsp_sel_c == SEL_BITS'(i)) begin
        bus_io.rsp_in_valid[i] = bus_io.rsp_out_valid;
        bus_io.rsp_out_ready   = bus_io.rsp_in_ready[i];
      end
    end
  end

  assign bus_io.rsp_in_data = {NUM_INPUTS{bus_io.rsp_out_data}};
  assign bus_io.rsp_in_tag  = {NUM_INPUTS{bus_io.rsp_out_tag[OUT_TAG_WIDTH-1:SEL_BITS]}};

  always_ff @(posedge clk) begin
    if (reset && bus_io.rsp_out_valid) begin
      assert (32'(rsp_sel_c) < NUM_INPUTS)
        else $error("vx_socket_mem_arb: response index %0d out of range", rsp_sel_c);
    end
  end

endmodule

// File: tb/tb_vx_socket_mem_arb.sv
// Self-checking bench: 4-input skid-buffered arbiter plus a 3-input combinational one.
module tb_vx_socket_mem_arb;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [9:0]  tag;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  int   m_ptr = 0;
  req_t m_q[$];

  always #5 clk = ~clk;

  vx_socket_mem_arb_if #(.NUM_INPUTS(4), .ADDR_WIDTH(32), .DATA_SIZE(4), .TAG_WIDTH(8)) a4 ();
  vx_socket_mem_arb_if #(.NUM_INPUTS(3), .ADDR_WIDTH(32), .DATA_SIZE(4), .TAG_WIDTH(8)) a3 ();

  vx_socket_mem_arb #(.NUM_INPUTS(4), .ADDR_WIDTH(32), .DATA_SIZE(4), .TAG_WIDTH(8), .OUT_REG(1))
    dut4 (.clk(clk), .reset(reset), .bus_io(a4.slave));

  vx_socket_mem_arb #(.NUM_INPUTS(3), .ADDR_WIDTH(32), .DATA_SIZE(4), .TAG_WIDTH(8), .OUT_REG(0))
    dut3 (.clk(clk), .reset(reset), .bus_io(a3.slave));

  function automatic int rr_pick(input int p, input logic [3:0] v, input int n);
    for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready4();
    int g;
    g = rr_pick(m_ptr, a4.req_in_valid, 4);
    if (!reset || g < 0 || m_q.size() >= 2) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  // Reference: 2-deep FIFO of accepted requests, pop before push at each clock.
  task automatic model_commit4();
    int   g;
    bit   acc;
    req_t r;
    if (!reset) begin
      m_q.delete();
      m_ptr = 0;
      return;
    end
    g   = rr_pick(m_ptr, a4.req_in_valid, 4);
    acc = (g >= 0) && (m_q.size() < 2);
    if (m_q.size() > 0 && a4.req_out_ready) void'(m_q.pop_front());
    if (acc) begin
      r.rw   = a4.req_in_rw[g];
      r.addr = a4.req_in_addr[g];
      r.data = a4.req_in_data[g];
      r.be   = a4.req_in_byteen[g];
      r.tag  = {a4.req_in_tag[g], 2'(g)};
      m_q.push_back(r);
      m_ptr = (g + 1) % 4;
    end
  endtask

  task automatic rand_fields4(input logic [3:0] v);
    a4.req_in_valid = v;
    for (int i = 0; i < 4; i++) begin
      a4.req_in_rw[i]     = 1'($urandom);
      a4.req_in_addr[i]   = $urandom;
      a4.req_in_data[i]   = $urandom;
      a4.req_in_byteen[i] = 4'($urandom);
      a4.req_in_tag[i]    = 8'($urandom);
    end
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(negedge clk);
      rand_fields4(4'b0000);
      a4.req_out_ready = 1'b1;
      #1;
      model_commit4();
    end
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      rand_fields4(4'hF);
      a4.req_out_ready = 1'b1;
      #1;
      tests++;
      if (a4.req_in_ready !== 4'b0000) begin
        fails++; $display("FAIL reset_ready: got %b expected 0000", a4.req_in_ready);
      end
      tests++;
      if (a4.req_out_valid !== 1'b0) begin
        fails++; $display("FAIL reset_out_valid: got %b expected 0", a4.req_out_valid);
      end
      model_commit4();
    end
    @(negedge clk);
    reset = 1'b1;
    rand_fields4(4'b0000);
    #1;
    tests++;
    if (a4.req_out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_release_valid: got %b expected 0", a4.req_out_valid);
    end
    model_commit4();
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rand_fields4(4'hF);
      a4.req_out_ready = 1'b1;
      #1;
      tests++;
      if (a4.req_in_ready !== (4'b0001 << (c % 4))) begin
        fails++; $display("FAIL rr_grant cycle %0d: got %b expected %b", c, a4.req_in_ready, 4'b0001 << (c % 4));
      end
      tests++;
      if (c == 0) begin
        if (a4.req_out_valid !== 1'b0) begin
          fails++; $display("FAIL rr_latency: out_valid %b expected 0", a4.req_out_valid);
        end
      end else if (a4.req_out_valid !== 1'b1 || a4.req_out_tag[1:0] !== 2'((c - 1) % 4)) begin
        fails++; $display("FAIL rr_out cycle %0d: valid %b sel %0d expected valid 1 sel %0d",
                          c, a4.req_out_valid, a4.req_out_tag[1:0], (c - 1) % 4);
      end
      model_commit4();
    end
    idle4(2);
  endtask

  task automatic test_single_input();
    @(negedge clk);
    rand_fields4(4'b0100);
    a4.req_in_tag[2] = 8'h5A;
    a4.req_out_ready = 1'b1;
    #1;
    tests++;
    if (a4.req_in_ready !== 4'b0100) begin
      fails++; $display("FAIL single_grant: got %b expected 0100", a4.req_in_ready);
    end
    model_commit4();
    @(negedge clk);
    rand_fields4(4'hF);
    #1;
    tests++;
    if (a4.req_out_valid !== 1'b1 || a4.req_out_tag !== 10'h16A) begin
      fails++; $display("FAIL single_tag: valid %b tag %h expected 1 16a", a4.req_out_valid, a4.req_out_tag);
    end
    tests++;
    if (a4.req_in_ready !== 4'b1000) begin
      fails++; $display("FAIL single_ptr: got %b expected 1000", a4.req_in_ready);
    end
    model_commit4();
    idle4(2);
  endtask

  task automatic test_backpressure();
    logic [7:0] t0, t1;
    int acc = 0;
    t0 = '0;
    t1 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rand_fields4(4'hF);
      a4.req_out_ready = 1'b0;
      if (c == 0) t0 = a4.req_in_tag[0];
      if (c == 1) t1 = a4.req_in_tag[1];
      #1;
      if (a4.req_in_ready !== 4'b0000) acc++;
      tests++;
      if (a4.req_in_ready !== ((c < 2) ? (4'b0001 << c) : 4'b0000)) begin
        fails++; $display("FAIL bp_ready cycle %0d: got %b", c, a4.req_in_ready);
      end
      if (c > 0) begin
        tests++;
        if (a4.req_out_valid !== 1'b1 || a4.req_out_tag !== {t0, 2'b00}) begin
          fails++; $display("FAIL bp_hold cycle %0d: valid %b tag %h expected 1 %h", c, a4.req_out_valid, a4.req_out_tag, {t0, 2'b00});
        end
      end
      model_commit4();
    end
    tests++;
    if (acc != 2) begin
      fails++; $display("FAIL bp_accepts: got %0d expected 2", acc);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rand_fields4(4'b0000);
      a4.req_out_ready = 1'b1;
      #1;
      tests++;
      if (c == 0 && (a4.req_out_valid !== 1'b1 || a4.req_out_tag !== {t0, 2'b00})) begin
        fails++; $display("FAIL bp_drain0: valid %b tag %h expected 1 %h", a4.req_out_valid, a4.req_out_tag, {t0, 2'b00});
      end else if (c == 1 && (a4.req_out_valid !== 1'b1 || a4.req_out_tag !== {t1, 2'b01})) begin
        fails++; $display("FAIL bp_drain1: valid %b tag %h expected 1 %h", a4.req_out_valid, a4.req_out_tag, {t1, 2'b01});
      end else if (c == 2 && a4.req_out_valid !== 1'b0) begin
        fails++; $display("FAIL bp_drain_empty: valid %b expected 0", a4.req_out_valid);
      end
      model_commit4();
    end
  endtask

  task automatic test_response();
    logic [9:0]  tg;
    logic        v;
    logic [3:0]  rdy;
    int          s;
    @(negedge clk);
    a4.rsp_out_valid = 1'b1;
    a4.rsp_out_tag   = 10'h16A;
    a4.rsp_out_data  = 32'hDEADBEEF;
    a4.rsp_in_ready  = 4'b1011;
    #1;
    tests++;
    if (a4.rsp_in_valid !== 4'b0100 || a4.rsp_out_ready !== 1'b0) begin
      fails++; $display("FAIL rsp_stall: valid %b ready %b expected 0100 0", a4.rsp_in_valid, a4.rsp_out_ready);
    end
    a4.rsp_in_ready = 4'b0100;
    #1;
    tests++;
    if (a4.rsp_out_ready !== 1'b1 || a4.rsp_in_tag[2] !== 8'h5A || a4.rsp_in_data[1] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rsp_handshake: ready %b tag %h data %h expected 1 5a deadbeef",
                        a4.rsp_out_ready, a4.rsp_in_tag[2], a4.rsp_in_data[1]);
    end
    model_commit4();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tg  = 10'($urandom);
      v   = 1'($urandom);
      rdy = 4'($urandom);
      s   = int'(tg[1:0]);
      a4.rsp_out_valid = v;
      a4.rsp_out_tag   = tg;
      a4.rsp_out_data  = $urandom;
      a4.rsp_in_ready  = rdy;
      #1;
      tests++;
      if (a4.rsp_in_valid !== (v ? (4'b0001 << s) : 4'b0000) || a4.rsp_out_ready !== rdy[s]
          || a4.rsp_in_tag[c % 4] !== tg[9:2]) begin
        fails++; $display("FAIL rsp_random %0d: valid %b ready %b tag %h expected sel %0d ready %b tag %h",
                          c, a4.rsp_in_valid, a4.rsp_out_ready, a4.rsp_in_tag[c % 4], s, rdy[s], tg[9:2]);
      end
      model_commit4();
    end
    a4.rsp_out_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rand_fields4(4'hF);
      a4.req_out_ready = 1'b0;
      #1;
      model_commit4();
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (a4.req_in_ready !== 4'b0000 || a4.req_out_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_during: ready %b valid %b expected 0000 0", a4.req_in_ready, a4.req_out_valid);
    end
    model_commit4();
    @(negedge clk);
    reset = 1'b1;
    rand_fields4(4'hF);
    #1;
    tests++;
    if (a4.req_out_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_flush: valid %b expected 0", a4.req_out_valid);
    end
    tests++;
    if (a4.req_in_ready !== 4'b0001) begin
      fails++; $display("FAIL midreset_ptr: ready %b expected 0001", a4.req_in_ready);
    end
    model_commit4();
    idle4(2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rand_fields4(4'($urandom));
      a4.req_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      tests++;
      if (a4.req_in_ready !== exp_ready4()) begin
        fails++; $display("FAIL rand_ready cycle %0d: got %b expected %b", c, a4.req_in_ready, exp_ready4());
      end
      tests++;
      if (a4.req_out_valid !== (m_q.size() > 0)) begin
        fails++; $display("FAIL rand_valid cycle %0d: got %b expected %0d", c, a4.req_out_valid, m_q.size() > 0);
      end
      if (m_q.size() > 0) begin
        tests++;
        if ({a4.req_out_rw, a4.req_out_addr, a4.req_out_data, a4.req_out_byteen, a4.req_out_tag}
            !== {m_q[0].rw, m_q[0].addr, m_q[0].data, m_q[0].be, m_q[0].tag}) begin
          fails++; $display("FAIL rand_payload cycle %0d: got %h/%h/%h expected %h/%h/%h", c,
                            a4.req_out_addr, a4.req_out_data, a4.req_out_tag, m_q[0].addr, m_q[0].data, m_q[0].tag);
        end
      end
      model_commit4();
    end
    idle4(3);
  endtask

  task automatic test_comb_mode();
    int p3 = 0;
    int g;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      a3.req_in_valid  = 3'($urandom);
      a3.req_out_ready = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        a3.req_in_rw[i]     = 1'($urandom);
        a3.req_in_addr[i]   = $urandom;
        a3.req_in_data[i]   = $urandom;
        a3.req_in_byteen[i] = 4'($urandom);
        a3.req_in_tag[i]    = 8'($urandom);
      end
      #1;
      g = rr_pick(p3, {1'b0, a3.req_in_valid}, 3);
      tests++;
      if (a3.req_out_valid !== (g >= 0)
          || a3.req_in_ready !== ((g >= 0 && a3.req_out_ready) ? (3'b001 << g) : 3'b000)) begin
        fails++; $display("FAIL comb_grant cycle %0d: valid %b ready %b expected grant %0d", c,
                          a3.req_out_valid, a3.req_in_ready, g);
      end
      if (g >= 0) begin
        tests++;
        if (a3.req_out_tag !== {a3.req_in_tag[g], 2'(g)} || a3.req_out_addr !== a3.req_in_addr[g]) begin
          fails++; $display("FAIL comb_payload cycle %0d: tag %h addr %h expected %h %h", c,
                            a3.req_out_tag, a3.req_out_addr, {a3.req_in_tag[g], 2'(g)}, a3.req_in_addr[g]);
        end
        if (a3.req_out_ready) p3 = (g + 1) % 3;
      end
    end
    @(negedge clk);
    a3.req_in_valid = 3'b000;
  endtask

  task automatic test_illegal_index();
    @(negedge clk);
    a3.rsp_out_valid = 1'b1;
    a3.rsp_out_tag   = {8'hA5, 2'b10};
    a3.rsp_in_ready  = 3'b000;
    #1;
    tests++;
    if (a3.rsp_in_valid !== 3'b100 || a3.rsp_out_ready !== 1'b0) begin
      fails++; $display("FAIL idx_legal: valid %b ready %b expected 100 0", a3.rsp_in_valid, a3.rsp_out_ready);
    end
    a3.rsp_out_valid = 1'b0;
    a3.rsp_out_tag   = {8'hA5, 2'b11};
    #1;
    tests++;
    if (a3.rsp_in_valid !== 3'b000 || a3.rsp_out_ready !== 1'b1) begin
      fails++; $display("FAIL idx_illegal: valid %b ready %b expected 000 1", a3.rsp_in_valid, a3.rsp_out_ready);
    end
    a3.rsp_out_tag = '0;
  endtask

  initial begin
    reset = 1'b0;
    rand_fields4(4'b0000);
    a4.req_out_ready = 1'b1;
    a4.rsp_in_ready  = '0;
    a4.rsp_out_valid = 1'b0;
    a4.rsp_out_data  = '0;
    a4.rsp_out_tag   = '0;
    a3.req_in_valid  = '0;
    a3.req_in_rw     = '0;
    a3.req_in_addr   = '0;
    a3.req_in_data   = '0;
    a3.req_in_byteen = '0;
    a3.req_in_tag    = '0;
    a3.req_out_ready = 1'b0;
    a3.rsp_in_ready  = '0;
    a3.rsp_out_valid = 1'b0;
    a3.rsp_out_data  = '0;
    a3.rsp_out_tag   = '0;

    test_reset();
    test_round_robin();
    test_single_input();
    test_backpressure();
    test_response();
    test_mid_reset();
    test_random();
    test_comb_mode();
    test_illegal_index();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
